// File: rtl/uart_mmio_if.sv
// Bus bundle between memory-control decode, the UART controller and the UART.
// master: CPU/UART side that drives requests and line events.
// slave:  the controller.
interface uart_mmio_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  sel;
  logic [1:0]            addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  we;
  logic                  re;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  tx_start;
  logic [7:0]            tx_data;
  logic                  tx_done;
  logic [7:0]            rx_data;
  logic                  rx_data_ready;
  logic                  clear_rx;

  modport master (
    output sel, addr, wdata, we, re, tx_done, rx_data, rx_data_ready,
    input  rdata, tx_start, tx_data, clear_rx
  );

  modport slave (
    input  sel, addr, wdata, we, re, tx_done, rx_data, rx_data_ready,
    output rdata, tx_start, tx_data, clear_rx
  );
endinterface

// File: rtl/uart_mmio_controller.sv
// Memory-mapped UART controller: TX/RX byte FIFOs, status register, and two
// small FSMs that pace tx_start per byte and acknowledge received bytes.
//
// TX FSM
//   state    | meaning
//   TX_IDLE  | waiting for a byte in the TX FIFO
//   TX_START | one-cycle tx_start pulse, tx_data already latched
//   TX_WAIT  | UART shifting the byte out, waiting for tx_done
//
// RX FSM
//   state    | meaning
//   RX_IDLE  | waiting for rx_data_ready; captures the byte on detection
//   RX_ACK   | clear_rx held until the UART drops rx_data_ready
module uart_mmio_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input logic       clk,
  input logic       reset,
  uart_mmio_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_WAIT} tx_state_t;
  typedef enum logic       {RX_IDLE, RX_ACK} rx_state_t;

  tx_state_t tx_state, tx_state_n;
  rx_state_t rx_state, rx_state_n;

  logic [7:0]       tx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] tx_wptr, tx_rptr;
  logic [CNT_W-1:0] tx_count;
  logic [7:0]       rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rx_wptr, rx_rptr;
  logic [CNT_W-1:0] rx_count;
  logic [7:0]       tx_data_q;
  logic             tx_overflow, rx_overrun;

  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_push_req, tx_push, tx_pop;
  logic rx_push_req, rx_push, rx_pop;
  logic stat_wr;
  logic [DATA_WIDTH-1:0] status;

  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == FULL_CNT);
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == FULL_CNT);

  // A full FIFO still accepts a push when the same edge frees a slot.
  assign tx_push_req = bus.sel && bus.we && (bus.addr == 2'd0);
  assign stat_wr     = bus.sel && bus.we && (bus.addr == 2'd2);
  assign tx_pop      = (tx_state == TX_IDLE) && !tx_empty;
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);
  assign rx_pop      = bus.sel && bus.re && (bus.addr == 2'd1) && !rx_empty;
  assign rx_push_req = (rx_state == RX_IDLE) && bus.rx_data_ready;
  assign rx_push     = rx_push_req && (!rx_full || rx_pop);

  // TX FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wptr] <= bus.wdata[7:0];
        tx_wptr         <= tx_wptr + PTR_W'(1);
      end
      if (tx_pop) tx_rptr <= tx_rptr + PTR_W'(1);
      tx_count <= tx_count + CNT_W'(tx_push) - CNT_W'(tx_pop);
    end
  end

  // RX FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) begin
        rx_mem[rx_wptr] <= bus.rx_data;
        rx_wptr         <= rx_wptr + PTR_W'(1);
      end
      if (rx_pop) rx_rptr <= rx_rptr + PTR_W'(1);
      rx_count <= rx_count + CNT_W'(rx_push) - CNT_W'(rx_pop);
    end
  end

  // Sticky error flags; a new error wins over a same-cycle W1C.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_overflow <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      tx_overflow <= (tx_overflow && !(stat_wr && bus.wdata[4])) || (tx_push_req && !tx_push);
      rx_overrun  <= (rx_overrun  && !(stat_wr && bus.wdata[5])) || (rx_push_req && !rx_push);
    end
  end

  // Byte latch for the UART; only changes when a new byte leaves the FIFO.
  always_ff @(posedge clk) begin
    if (reset)       tx_data_q <= 8'h00;
    else if (tx_pop) tx_data_q <= tx_mem[tx_rptr];
  end

  // FSM state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      rx_state <= RX_IDLE;
    end else begin
      tx_state <= tx_state_n;
      rx_state <= rx_state_n;
    end
  end

  // TX next state; tx_done outside TX_WAIT is ignored.
  always_comb begin
    tx_state_n = tx_state;
    case (tx_state)
      TX_IDLE:  if (!tx_empty) tx_state_n = TX_START;
      TX_START: tx_state_n = TX_WAIT;
      TX_WAIT:  if (bus.tx_done) tx_state_n = TX_IDLE;
      default:  tx_state_n = TX_IDLE;
    endcase
  end

  // RX next state; one capture per rx_data_ready assertion.
  always_comb begin
    rx_state_n = rx_state;
    case (rx_state)
      RX_IDLE: if (bus.rx_data_ready) rx_state_n = RX_ACK;
      RX_ACK:  if (!bus.rx_data_ready) rx_state_n = RX_IDLE;
      default: rx_state_n = RX_IDLE;
    endcase
  end

  assign bus.tx_start = (tx_state == TX_START);
  assign bus.tx_data  = tx_data_q;
  assign bus.clear_rx = (rx_state == RX_ACK) && bus.rx_data_ready;

  // Status word assembly.
  always_comb begin
    status               = '0;
    status[0]            = tx_full;
    status[1]            = tx_empty;
    status[2]            = !rx_empty;
    status[3]            = rx_full;
    status[4]            = tx_overflow;
    status[5]            = rx_overrun;
    status[6]            = (tx_state != TX_IDLE);
    status[8 +: CNT_W]   = tx_count;
    status[16 +: CNT_W]  = rx_count;
  end

  // Combinational read mux.
  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      2'd1:    if (!rx_empty) bus.rdata = {{(DATA_WIDTH-8){1'b0}}, rx_mem[rx_rptr]};
      2'd2:    bus.rdata = status;
      default: bus.rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_mmio_controller.sv
// Bench for uart_mmio_controller: scoreboard queues for TX and RX bytes,
// a UART-side tx_done responder and a TX line monitor.
module tb_uart_mmio_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;

  uart_mmio_if #(.DATA_WIDTH(32)) bus ();

  uart_mmio_controller #(.DATA_WIDTH(32), .FIFO_DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  int rx_cnt = 0;

  // Monitor-owned state.
  bit tx_in_flight = 1'b0;
  int tx_starts = 0;

  // Responder control (main writes, responder reads).
  bit auto_done = 1'b0;
  int manual_req = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.sel = 1'b0; bus.we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.sel = 1'b1; bus.re = 1'b1; bus.addr = a;
    #1 d = bus.rdata;
    @(negedge clk);
    bus.sel = 1'b0; bus.re = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(2'd2, d);
    check_val(tag, d, exp);
  endtask

  task automatic rx_read();
    logic [31:0] d;
    bus_read(2'd1, d);
    if (rx_exp.size() > 0) begin
      check_val("rx_data", d, {24'h0, rx_exp.pop_front()});
      rx_cnt--;
    end else begin
      check_val("rx_empty_read", d, 32'h0);
    end
  endtask

  task automatic tx_send(input logic [7:0] b, input bit accepted);
    if (accepted) tx_exp.push_back(b);
    bus_write(2'd0, {24'h0, b});
  endtask

  // UART stand-in: raise rx_data_ready, watch clear_rx each cycle, then drop.
  task automatic rx_send(input logic [7:0] b, input int hold);
    @(negedge clk);
    bus.rx_data = b; bus.rx_data_ready = 1'b1;
    if (rx_cnt < 8) begin
      rx_exp.push_back(b);
      rx_cnt++;
    end
    #1 check_val("clear_rx_before_detect", {31'h0, bus.clear_rx}, 32'h0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_val("clear_rx_hold", {31'h0, bus.clear_rx}, 32'h1);
    end
    bus.rx_data_ready = 1'b0;
    #1 check_val("clear_rx_drop", {31'h0, bus.clear_rx}, 32'h0);
    @(negedge clk);
  endtask

  task automatic wait_tx_drain(input int budget);
    int n = 0;
    while ((tx_exp.size() != 0 || tx_in_flight) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val("tx_drain", tx_exp.size() + int'(tx_in_flight), 32'h0);
  endtask

  // tx_done responder: 10 cycles after each tx_start when enabled, or on request.
  initial begin : tx_done_responder
    int done_cnt = 0;
    int manual_ack = 0;
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      bus.tx_done = 1'b0;
      if (manual_req != manual_ack) begin
        bus.tx_done = 1'b1;
        manual_ack  = manual_req;
      end
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) bus.tx_done = 1'b1;
      end
      if (auto_done && bus.tx_start && done_cnt == 0) done_cnt = 10;
    end
  end

  // TX line monitor: byte order, pulse width, hold through WAIT, idle gap.
  initial begin : tx_monitor
    logic [7:0] held = 8'h00;
    bit prev_start = 1'b0;
    int c = 0;
    int last_done = -100;
    forever begin
      @(negedge clk);
      c++;
      if (reset) begin
        tx_in_flight = 1'b0;
        prev_start   = 1'b0;
      end else begin
        if (tx_in_flight && !bus.tx_start)
          check_val("tx_data_hold", {24'h0, bus.tx_data}, {24'h0, held});
        if (bus.tx_done && tx_in_flight) begin
          tx_in_flight = 1'b0;
          last_done    = c;
        end
        if (bus.tx_start) begin
          check_val("tx_start_width", {31'h0, prev_start}, 32'h0);
          check_val("tx_idle_gap", {31'h0, (c - last_done) >= 1}, 32'h1);
          check_val("tx_exp_avail", {31'h0, tx_exp.size() > 0}, 32'h1);
          if (tx_exp.size() > 0)
            check_val("tx_data", {24'h0, bus.tx_data}, {24'h0, tx_exp.pop_front()});
          held         = bus.tx_data;
          tx_in_flight = 1'b1;
          tx_starts++;
        end
        prev_start = bus.tx_start;
      end
    end
  end

  initial begin : main
    logic [31:0] d;
    int s0;
    bus.sel = 1'b0; bus.we = 1'b0; bus.re = 1'b0; bus.addr = 2'd0; bus.wdata = '0;
    bus.rx_data = 8'h00; bus.rx_data_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state.
    #1;
    check_val("rst_tx_start", {31'h0, bus.tx_start}, 32'h0);
    check_val("rst_clear_rx", {31'h0, bus.clear_rx}, 32'h0);
    check_val("rst_tx_data", {24'h0, bus.tx_data}, 32'h0);
    chk_status("rst_status", 32'h0000_0002);
    bus_read(2'd0, d); check_val("addr0_read", d, 32'h0);
    bus_read(2'd3, d); check_val("addr3_read", d, 32'h0);
    rx_read();

    // Two bytes with tx_done 10 cycles after each start.
    auto_done = 1'b1;
    s0 = tx_starts;
    tx_send(8'h41, 1'b1);
    tx_send(8'h42, 1'b1);
    wait_tx_drain(200);
    check_val("tx_two_starts", tx_starts - s0, 32'd2);
    chk_status("tx_idle_status", 32'h0000_0002);

    // FIFO fill with tx_done held low, overflow and W1C.
    auto_done = 1'b0;
    for (int i = 1; i <= 9; i++) tx_send(8'(i), 1'b1);
    chk_status("tx_full_status", 32'h0000_0841);
    tx_send(8'h0A, 1'b0);
    chk_status("tx_overflow_status", 32'h0000_0851);
    bus_write(2'd2, 32'h0000_0010);
    chk_status("tx_ovf_cleared", 32'h0000_0841);
    auto_done = 1'b1;
    manual_req++;
    wait_tx_drain(400);
    chk_status("tx_drained_status", 32'h0000_0002);

    // Single RX byte held for 5 cycles.
    rx_send(8'h5A, 5);
    chk_status("rx_one_status", 32'h0001_0006);
    rx_read();
    chk_status("rx_popped_status", 32'h0000_0002);

    // Nine RX bytes without reads: last one overruns.
    for (int i = 0; i < 9; i++) rx_send(8'h10 + 8'(i), 1);
    chk_status("rx_full_status", 32'h0008_002E);
    for (int i = 0; i < 8; i++) rx_read();
    chk_status("rx_drained_status", 32'h0000_0022);
    rx_read();
    bus_write(2'd2, 32'h0000_0020);
    chk_status("rx_ovr_cleared", 32'h0000_0002);

    // Reset while TX is in WAIT and RX is in ACK.
    auto_done = 1'b0;
    tx_send(8'h77, 1'b1);
    repeat (4) @(negedge clk);
    bus.rx_data = 8'hC3; bus.rx_data_ready = 1'b1;
    @(negedge clk);
    check_val("pre_rst_clear_rx", {31'h0, bus.clear_rx}, 32'h1);
    check_val("pre_rst_busy", {31'h0, tx_in_flight}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_val("mid_rst_tx_start", {31'h0, bus.tx_start}, 32'h0);
    check_val("mid_rst_clear_rx", {31'h0, bus.clear_rx}, 32'h0);
    bus.addr = 2'd2;
    #1 check_val("mid_rst_status", bus.rdata, 32'h0000_0002);
    reset = 1'b0;
    bus.rx_data_ready = 1'b0;
    auto_done = 1'b1;
    s0 = tx_starts;
    tx_send(8'h99, 1'b1);
    wait_tx_drain(200);
    check_val("post_rst_starts", tx_starts - s0, 32'd1);
    chk_status("post_rst_status", 32'h0000_0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_mmio_controller.md
Name: uart_mmio_controller

Overview:
- Memory-mapped UART controller between the core's memory-control decode and the UART block.
- Replaces the raw tx_start/tx_data/clear_rx registers with an 8-entry TX FIFO, an 8-entry RX FIFO and a status register.
- Sequences tx_start pulses per byte and performs the rx_data_ready/clear_rx handshake autonomously, so firmware never polls bit-level timing.
- Runs on the same clock as the UART.

Parameters:
- DATA_WIDTH, 32, CPU bus width.
- FIFO_DEPTH, 8, entries per FIFO; must be a power of 2, minimum 2.
- CNT_W, $clog2(FIFO_DEPTH)+1, occupancy counter width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- sel  in  1  this block is addressed by memory control.
- addr  in  2  register select: 0 TX_DATA, 1 RX_DATA, 2 STATUS, 3 reserved.
- wdata  in  DATA_WIDTH  CPU write data.
- we  in  1  CPU write strobe, qualified by sel.
- re  in  1  CPU read strobe, qualified by sel; pops RX_DATA.
- rdata  out  DATA_WIDTH  combinational read data.
- tx_start  out  1  one-cycle start pulse to the UART transmitter.
- tx_data  out  8  byte presented to the UART; held stable from tx_start until tx_done.
- tx_done  in  1  one-cycle pulse from the UART when the stop bit completes.
- rx_data  in  8  received byte from the UART.
- rx_data_ready  in  1  level signal: the UART holds an unread byte.
- clear_rx  out  1  acknowledge to the UART; high until rx_data_ready falls.

Behaviour:
- Reset (synchronous, active-high):
  - FIFOs emptied; pointers and counts set to 0; sticky flags cleared.
  - Both FSMs enter IDLE.
  - tx_start=0, tx_data=8'h00, clear_rx=0.
- Reads (rdata, combinational):
  - addr 0 reads 0.
  - addr 1 reads {24'b0, RX head}, or 0 if the RX FIFO is empty.
  - addr 2 reads STATUS:
    - bit0 tx_full, bit1 tx_empty, bit2 rx_valid, bit3 rx_full
    - bit4 tx_overflow (sticky), bit5 rx_overrun (sticky), bit6 tx_busy
    - bits[8+CNT_W-1:8] tx_count, bits[16+CNT_W-1:16] rx_count
    - all other bits 0.
  - addr 3 reads 0.
- Writes:
  - sel&we to addr 0 pushes wdata[7:0] into the TX FIFO. If the FIFO is full, the byte is dropped and tx_overflow is set.
  - sel&we to addr 2 applies write-1-to-clear: wdata[4] clears tx_overflow, wdata[5] clears rx_overrun.
  - Writes to addr 1 and addr 3 are ignored.
- RX pop: sel&re with addr 1 and RX non-empty advances the RX read pointer at the edge. A pop on an empty FIFO has no effect.
- TX FSM:
  - IDLE: if TX non-empty, latch head into tx_data, pop, go to START.
  - START: tx_start=1 for exactly one cycle, go to WAIT.
  - WAIT: hold tx_data; on tx_done go to IDLE.
  - tx_busy=1 in START and WAIT.
  - Back-to-back bytes: minimum 1 IDLE cycle between tx_done and the next tx_start.
  - tx_done received outside WAIT is ignored.
- RX FSM:
  - IDLE: on rx_data_ready=1, push rx_data into the RX FIFO. If the FIFO is full, the byte is discarded and rx_overrun is set. Either way, go to ACK.
  - ACK: clear_rx=1; on rx_data_ready=0 go to IDLE with clear_rx=0 in that cycle.
  - Exactly one push per rx_data_ready assertion.
- Simultaneous events:
  - CPU push and TX FSM pop in the same cycle: both take effect and tx_count is unchanged. A push is accepted when the FIFO is full but popped this cycle.
  - CPU pop and RX FSM push in the same cycle: both take effect. A push into a full FIFO with a simultaneous pop is accepted with no overrun.
  - Sticky flag set and W1C clear in the same cycle: set wins.
- Wrap-around: pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. Counts saturate naturally at 0 and FIFO_DEPTH, never exceeding either.
- Reset mid-operation: reset in WAIT or ACK aborts immediately. tx_start and clear_rx are 0 in the first post-reset cycle, and the in-flight byte is lost.

Test Plan:
- Reset then read STATUS -> rdata=32'h0000_0002 (tx_empty only); tx_start=0, clear_rx=0.
- Write 8'h41 then 8'h42 to addr 0, tx_done pulsed 10 cycles after each tx_start:
  - two single-cycle tx_start pulses, tx_data=8'h41 then 8'h42;
  - tx_data held stable through WAIT;
  - ≥1 idle cycle between tx_done and the second tx_start.
- Hold tx_done low and write 9 bytes:
  - first byte leaves the FIFO, leaving 8 entries (tx_full=1);
  - 9th byte is accepted with no overflow (room from the pop);
  - a 10th write sets tx_overflow (STATUS bit4=1);
  - write STATUS with 32'h10 -> bit4=0.
- Assert rx_data_ready with rx_data=8'h5A for 5 cycles:
  - one push, rx_count=1;
  - clear_rx high from the cycle after detection until rx_data_ready falls;
  - read addr 1 returns 32'h0000_005A and rx_count becomes 0.
- Deliver 9 RX bytes with no reads -> rx_full=1, rx_overrun=1; 8 reads return the first 8 bytes in order; then rx_valid=0 and a further read returns 0.
- Assert reset during TX WAIT and RX ACK -> next cycle tx_start=0, clear_rx=0, STATUS=32'h0000_0002; a new write transmits normally.
